// File: rtl/mem_access_stage.sv
// Y86-64 memory stage. It accepts one instruction from execute and performs its data-memory
// access after a fixed wait, then holds the result for writeback until it is consumed.
module mem_access_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int MEM_LAT   = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  icode_o,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic        dmem_error_o
);

    localparam int              AW       = $clog2(MEM_BYTES);
    localparam int              CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(MEM_LAT - 1);
    localparam logic [63:0]     ADDR_MAX = 64'(MEM_BYTES - 8);

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic is_read(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
    endfunction

    function automatic logic is_write(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    endfunction

    // An 8-byte word must fit entirely inside memory; no wrap-around.
    function automatic logic addr_fault(input logic [63:0] addr);
        return addr > ADDR_MAX;
    endfunction

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r;
    logic          in_ready_r, in_ready_nx_s;
    logic          out_valid_r, out_valid_nx_s;
    logic [3:0]    icode_r;
    logic [63:0]   vale_r;
    logic [63:0]   valm_r;
    logic          err_r;
    logic [63:0]   addr_r;
    logic [63:0]   wdata_r;
    logic          rd_r;
    logic          wr_r;
    logic [7:0]    mem_r [MEM_BYTES];

    logic          accept_s;
    logic          access_s;
    logic          addr_err_s;
    logic [AW-1:0] addr_idx_s;
    logic [63:0]   rdata_s;

    assign accept_s   = (state_r == ST_IDLE) && in_valid_i;
    assign access_s   = (state_r == ST_WAIT) && (cnt_r == '0);
    assign addr_err_s = addr_fault(addr_r);
    assign addr_idx_s = addr_r[AW-1:0];

    assign in_ready_o   = in_ready_r;
    assign out_valid_o  = out_valid_r;
    assign icode_o      = icode_r;
    assign valE_o       = vale_r;
    assign valM_o       = valm_r;
    assign dmem_error_o = err_r;

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_nx_s = (is_read(icode_i) || is_write(icode_i)) ? ST_WAIT : ST_HOLD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == '0) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they register in step with it.
    always_comb begin
        in_ready_nx_s  = 1'b0;
        out_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: in_ready_nx_s  = 1'b1;
            ST_HOLD: out_valid_nx_s = 1'b1;
            ST_WAIT: in_ready_nx_s  = 1'b0;
            default: in_ready_nx_s  = 1'b0;
        endcase
    end

    // Little-endian word read at the latched address (unaligned allowed).
    always_comb begin
        rdata_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            rdata_s[8*i +: 8] = mem_r[addr_idx_s + AW'(i)];
        end
    end

    // Instruction latch, wait counter and result registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r   <= '0;
            icode_r <= 4'd0;
            vale_r  <= 64'd0;
            valm_r  <= 64'd0;
            err_r   <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else if (accept_s) begin
            icode_r <= icode_i;
            vale_r  <= valE_i;
            valm_r  <= 64'd0;
            err_r   <= 1'b0;
            cnt_r   <= CNT_INIT;
            rd_r    <= is_read(icode_i);
            wr_r    <= is_write(icode_i);
            addr_r  <= ((icode_i == IPOPQ) || (icode_i == IRET)) ? valA_i : valE_i;
            wdata_r <= (icode_i == ICALL) ? valP_i : valA_i;
        end else if (state_r == ST_WAIT) begin
            if (cnt_r != '0) begin
                cnt_r <= cnt_r - CW'(1);
            end else begin
                valm_r <= (rd_r && !addr_err_s) ? rdata_s : 64'd0;
                err_r  <= addr_err_s;
            end
        end
    end

    // Data memory write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (access_s && wr_r && !addr_err_s) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[addr_idx_s + AW'(i)] <= wdata_r[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random traffic, checked against
// a byte-array memory model that applies the access table directly.
module tb_mem_access_stage;

    localparam int MEM_BYTES = 1024;
    localparam int MEM_LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode_in;
    logic [63:0] vale_in;
    logic [63:0] vala_in;
    logic [63:0] valp_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode_out;
    logic [63:0] vale_out;
    logic [63:0] valm_out;
    logic        dmem_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [3:0]  exp_icode;
    logic [63:0] exp_vale;
    logic [63:0] exp_valm;
    logic        exp_err;

    mem_access_stage #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(MEM_LAT)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .icode_i      (icode_in),
        .valE_i       (vale_in),
        .valA_i       (vala_in),
        .valP_i       (valp_in),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .icode_o      (icode_out),
        .valE_o       (vale_out),
        .valM_o       (valm_out),
        .dmem_error_o (dmem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_icode"},     64'(icode_out), 64'd0);
        chk({tag, "_valE"},      vale_out,       64'd0);
        chk({tag, "_valM"},      valm_out,       64'd0);
        chk({tag, "_err"},       64'(dmem_err),  64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return 64'($urandom_range(0, MEM_BYTES - 8));
        else if (r == 7) return 64'(MEM_BYTES - 8 + $urandom_range(1, 8));
        else if (r == 8) return {$urandom, $urandom};
        else             return 64'(MEM_BYTES - 8);
    endfunction

    // Reference: decide the access from the icode table, apply it to ref_mem, predict outputs.
    task automatic model(input logic [3:0] ic, input logic [63:0] e, a, p, output int lat);
        logic [63:0] addr;
        logic [63:0] wd;
        bit rd;
        bit wr;
        rd = 0; wr = 0; addr = 64'd0; wd = 64'd0;
        case (ic)
            4'h4, 4'hA: begin wr = 1; addr = e; wd = a; end
            4'h8:       begin wr = 1; addr = e; wd = p; end
            4'h5:       begin rd = 1; addr = e; end
            4'h9, 4'hB: begin rd = 1; addr = a; end
            default:    begin rd = 0; wr = 0; end
        endcase
        exp_icode = ic;
        exp_vale  = e;
        exp_valm  = 64'd0;
        exp_err   = 1'b0;
        lat       = 1;
        if (rd || wr) begin
            lat = MEM_LAT + 1;
            if (addr > 64'(MEM_BYTES - 8)) begin
                exp_err = 1'b1;
            end else if (rd) begin
                for (int k = 0; k < 8; k++) exp_valm[8*k +: 8] = ref_mem[int'(addr) + k];
            end else begin
                for (int k = 0; k < 8; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
            end
        end
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_icode"},    64'(icode_out), 64'(exp_icode));
        chk({tag, "_valE"},     vale_out,       exp_vale);
        chk({tag, "_valM"},     valm_out,       exp_valm);
        chk({tag, "_err"},      64'(dmem_err),  64'(exp_err));
        chk({tag, "_in_ready"}, 64'(in_ready),  64'd0);
    endtask

    // Present one instruction, wait (bounded) for out_valid while driving junk, check result.
    task automatic issue(input logic [3:0] ic, input logic [63:0] e, a, p);
        int exp_lat;
        int lat;
        bit seen;
        model(ic, e, a, p, exp_lat);
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; icode_in = ic; vale_in = e; vala_in = a; valp_in = p;
        @(posedge clk);
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1;
            end else begin
                chk("busy_in_ready", 64'(in_ready), 64'd0);
                in_valid  = 1'($urandom_range(0, 1));
                icode_in  = 4'($urandom_range(0, 15));
                vale_in   = rand_addr();
                vala_in   = rand_addr();
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        check_result("result");
    endtask

    // Stall in HOLD for a number of cycles, then let writeback consume.
    task automatic finish(input int hold);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            icode_in = 4'h4;
            vale_in  = 64'd0;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            check_result("hold");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready),  64'd1);
    endtask

    task automatic txn(input logic [3:0] ic, input logic [63:0] e, a, p, input int hold);
        issue(ic, e, a, p);
        finish(hold);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        icode_in = 4'd0; vale_in = 64'd0; vala_in = 64'd0; valp_in = 64'd0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // Give every byte a known value.
        for (int i = 0; i < MEM_BYTES / 8; i++) txn(4'h4, 64'(i * 8), {$urandom, $urandom}, 64'd0, 0);

        // Store then load at 0x10.
        txn(4'h4, 64'h10, 64'h1122334455667788, 64'd0, 1);
        issue(4'h5, 64'h10, 64'd0, 64'd0);
        chk("raw_valM", valm_out, 64'h1122334455667788);
        finish(0);

        // Non-memory op.
        issue(4'h6, 64'd3, 64'd0, 64'd0);
        chk("iopq_valE", vale_out, 64'd3);
        chk("iopq_valM", valm_out, 64'd0);
        finish(0);
        txn(4'h5, 64'h10, 64'd0, 64'd0, 0);

        // CALL pushes valP; RET and POPQ read it back through valA.
        txn(4'h8, 64'h20, 64'd0, 64'h40, 0);
        issue(4'h9, 64'd0, 64'h20, 64'd0);
        chk("ret_valM", valm_out, 64'h40);
        finish(0);
        issue(4'hB, 64'h28, 64'h20, 64'd0);
        chk("popq_valM", valm_out, 64'h40);
        finish(0);

        // Address errors and the last legal word.
        issue(4'h5, 64'(MEM_BYTES - 4), 64'd0, 64'd0);
        chk("oob_rd_err", 64'(dmem_err), 64'd1);
        finish(0);
        issue(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_0BAD_F00D, 64'd0);
        chk("oob_wr_err", 64'(dmem_err), 64'd1);
        finish(0);
        txn(4'h5, 64'(MEM_BYTES - 8), 64'd0, 64'd0, 0);
        txn(4'h5, 64'd0, 64'd0, 64'd0, 0);
        txn(4'h5, 64'h3FD, 64'd0, 64'd0, 0);

        // Writeback back-pressure.
        txn(4'h5, 64'h10, 64'd0, 64'd0, 5);

        // Reset during the wait of a store: the store must not land.
        @(negedge clk);
        in_valid = 1'b1; icode_in = 4'h4; vale_in = 64'h100; vala_in = 64'hA5A5_A5A5_A5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        txn(4'h5, 64'h100, 64'd0, 64'd0, 0);

        // Reset while a read result is held.
        issue(4'h5, 64'h10, 64'd0, 64'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        repeat (150) begin
            txn(4'($urandom_range(0, 15)), rand_addr(), rand_addr(), {$urandom, $urandom},
                $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
